// File: rtl/fm7_io_pkg.sv
// Shared constants for the FM-7 $FD00-$FD03 register block: offsets, bit indices,
// default timer divisor and the $FD03 status byte builder.
package fm7_io_pkg;

    localparam int TIMER_DIV_DFLT = 32544;

    localparam logic [1:0] OFS_FD00 = 2'd0;
    localparam logic [1:0] OFS_FD01 = 2'd1;
    localparam logic [1:0] OFS_FD02 = 2'd2;
    localparam logic [1:0] OFS_FD03 = 2'd3;

    localparam int MASK_KEY = 0;
    localparam int MASK_TMR = 1;

    localparam int ST_KEY = 0;
    localparam int ST_TMR = 2;

    typedef enum logic [1:0] {
        SEL_FD00 = OFS_FD00,
        SEL_FD01 = OFS_FD01,
        SEL_FD02 = OFS_FD02,
        SEL_FD03 = OFS_FD03
    } reg_sel_e;

    // Status bits are active-low; unused bits read back as 1.
    function automatic logic [7:0] fd03_status(input logic key_flag, input logic timer_flag);
        logic [7:0] r;
        r         = 8'hFF;
        r[ST_KEY] = ~key_flag;
        r[ST_TMR] = ~timer_flag;
        return r;
    endfunction

endpackage

// File: rtl/fm7_irq_ctrl_if.sv
// CPU-side bus of the FM-7 IRQ/keyboard block: decoded strobes, data and IRQ line.
interface fm7_irq_ctrl_if;
    // Strobes are active-low and stay low for the whole access; the block acts once,
    // on the CLK where a strobe is seen high after having been low. DIN must be held
    // through that CLK. KEY_STB is a one-CLK qualifier for KEY_CODE.
    logic       RFD00n;
    logic       RFD01n;
    logic       RFD02n;
    logic       RFD03n;
    logic       WFD02n;
    logic [7:0] DIN;
    logic [8:0] KEY_CODE;
    logic       KEY_STB;
    logic [7:0] DOUT;
    logic       DOE;
    logic       IRQn;

    modport master (
        output RFD00n, RFD01n, RFD02n, RFD03n, WFD02n, DIN, KEY_CODE, KEY_STB,
        input  DOUT, DOE, IRQn
    );

    modport slave (
        input  RFD00n, RFD01n, RFD02n, RFD03n, WFD02n, DIN, KEY_CODE, KEY_STB,
        output DOUT, DOE, IRQn
    );
endinterface

// File: rtl/fm7_irq_timer.sv
// Free-running periodic timer: counts 0..TIMER_DIV-1 and flags the wrap cycle.
module fm7_irq_timer
    import fm7_io_pkg::*;
#(
    parameter int TIMER_DIV = TIMER_DIV_DFLT,
    parameter int CNT_W     = 16
) (
    input  logic CLK,
    input  logic RSTn,
    output logic o_wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMER_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign o_wrap = w_last;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fm7_irq_ctrl.sv
// FM-7 main-CPU $FD00-$FD03 block: key latch, 2.034 ms timer flag, IRQ mask and IRQn.
// Optional BREAK/FIRQ support is built when FM7_BREAK_FIRQ_EN is defined.
module fm7_irq_ctrl
    import fm7_io_pkg::*;
#(
    parameter int TIMER_DIV = TIMER_DIV_DFLT,
    parameter int CNT_W     = 16
) (
    input  logic CLK,
    input  logic RSTn,
`ifdef FM7_BREAK_FIRQ_EN
    input  logic BREAKn,
    output logic FIRQn,
`endif
    fm7_irq_ctrl_if.slave bus
);

    // $FD00 reads have no side effect, so only the other strobes keep history.
    logic       r_prev_rd01;
    logic       r_prev_rd03;
    logic       r_prev_wr02;
    logic [8:0] r_key_latch;
    logic       r_key_flag;
    logic       r_timer_flag;
    logic [1:0] r_mask;
    logic       r_irqn;

    logic       w_end_rd01;
    logic       w_end_rd03;
    logic       w_end_wr02;
    logic       w_wrap;
    logic [7:0] w_fd02;
    reg_sel_e   w_sel;
    logic       w_rd_any;
    logic [7:0] w_dout;

    assign w_end_rd01 = ~r_prev_rd01 & bus.RFD01n;
    assign w_end_rd03 = ~r_prev_rd03 & bus.RFD03n;
    assign w_end_wr02 = ~r_prev_wr02 & bus.WFD02n;

    fm7_irq_timer #(
        .TIMER_DIV (TIMER_DIV),
        .CNT_W     (CNT_W)
    ) u_timer (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .o_wrap (w_wrap)
    );

    // Flags: a set arriving on the same CLK as a clear always wins.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_prev_rd01  <= 1'b1;
            r_prev_rd03  <= 1'b1;
            r_prev_wr02  <= 1'b1;
            r_key_latch  <= '0;
            r_key_flag   <= 1'b0;
            r_timer_flag <= 1'b0;
            r_mask       <= '0;
            r_irqn       <= 1'b1;
        end else begin
            r_prev_rd01 <= bus.RFD01n;
            r_prev_rd03 <= bus.RFD03n;
            r_prev_wr02 <= bus.WFD02n;

            if (bus.KEY_STB) begin
                r_key_latch <= bus.KEY_CODE;
                r_key_flag  <= 1'b1;
            end else if (w_end_rd01) begin
                r_key_flag <= 1'b0;
            end

            if (w_wrap) begin
                r_timer_flag <= 1'b1;
            end else if (w_end_rd03) begin
                r_timer_flag <= 1'b0;
            end

            if (w_end_wr02) begin
                r_mask[MASK_TMR] <= bus.DIN[2];
                r_mask[MASK_KEY] <= bus.DIN[0];
            end

            r_irqn <= ~((r_key_flag & r_mask[MASK_KEY]) | (r_timer_flag & r_mask[MASK_TMR]));
        end
    end

`ifdef FM7_BREAK_FIRQ_EN
    logic r_brk_s1;
    logic r_brk_s2;
    logic r_brk_s3;
    logic r_prev_rd02;
    logic r_brk_flag;
    logic r_firqn;
    logic w_end_rd02;

    assign w_end_rd02 = ~r_prev_rd02 & bus.RFD02n;

    // BREAKn is asynchronous: two flops to synchronize, a third to find the falling edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_brk_s1    <= 1'b1;
            r_brk_s2    <= 1'b1;
            r_brk_s3    <= 1'b1;
            r_prev_rd02 <= 1'b1;
            r_brk_flag  <= 1'b0;
            r_firqn     <= 1'b1;
        end else begin
            r_brk_s1    <= BREAKn;
            r_brk_s2    <= r_brk_s1;
            r_brk_s3    <= r_brk_s2;
            r_prev_rd02 <= bus.RFD02n;
            if (r_brk_s3 & ~r_brk_s2) begin
                r_brk_flag <= 1'b1;
            end else if (w_end_rd02) begin
                r_brk_flag <= 1'b0;
            end
            r_firqn <= ~r_brk_flag;
        end
    end

    assign FIRQn  = r_firqn;
    assign w_fd02 = {6'b111111, ~r_brk_flag, 1'b1};
`else
    assign w_fd02 = 8'hFF;
`endif

    // Simultaneous read strobes are illegal; the lowest address wins.
    always_comb begin
        w_rd_any = 1'b1;
        w_sel    = SEL_FD00;
        if (!bus.RFD00n) begin
            w_sel = SEL_FD00;
        end else if (!bus.RFD01n) begin
            w_sel = SEL_FD01;
        end else if (!bus.RFD02n) begin
            w_sel = SEL_FD02;
        end else if (!bus.RFD03n) begin
            w_sel = SEL_FD03;
        end else begin
            w_rd_any = 1'b0;
        end
    end

    always_comb begin
        w_dout = 8'hFF;
        if (w_rd_any) begin
            case (w_sel)
                SEL_FD00: w_dout = {7'b1111111, r_key_latch[8]};
                SEL_FD01: w_dout = r_key_latch[7:0];
                SEL_FD02: w_dout = w_fd02;
                SEL_FD03: w_dout = fd03_status(r_key_flag, r_timer_flag);
                default:  w_dout = 8'hFF;
            endcase
        end
    end

    assign bus.DOUT = w_dout;
    assign bus.DOE  = w_rd_any;
    assign bus.IRQn = r_irqn;

endmodule
